// File: rtl/fifo_read_ctrl.sv
// Read-side drain controller: pops the async FIFO in bursts or single words into a
// 2-entry skid buffer feeding a valid/ready stream. Optional checker: FIFO_RD_SEQ_CHECK_EN.
module fifo_read_ctrl #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   input  logic             r_almost_empty,
   output logic             rinc,
   input  logic             enable,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] rd_count,
   output logic             busy,
   output logic             seq_err
);

   localparam int unsigned          BCNT_W       = 8;
   localparam logic [BCNT_W-1:0]    LP_BCNT_LAST = BCNT_W'(BURST_LEN - 1);
   localparam logic [1:0]           LP_OCC_FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BURST  = 2'd1,
      ST_SINGLE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [BCNT_W-1:0] r_bcnt;
   logic [BCNT_W-1:0] w_bcnt_nxt;
   logic [1:0]        r_occ;
   logic [DSIZE-1:0]  r_buf0;
   logic [DSIZE-1:0]  r_buf1;
   logic [CNT_W-1:0]  r_rd_count;
   logic              w_rinc;
   logic              w_can_pop;
   logic              w_pop_dn;

   // State register
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_state <= ST_IDLE;
         r_bcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_bcnt  <= w_bcnt_nxt;
      end
   end

   // Pop gate never looks at m_ready, only at registered occupancy
   assign w_can_pop = enable && !rempty && (r_occ < LP_OCC_FULL);

   // Next state and pop strobe
   always_comb begin
      w_state_nxt = r_state;
      w_bcnt_nxt  = r_bcnt;
      w_rinc      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable && !r_almost_empty) begin
               w_state_nxt = ST_BURST;
               w_bcnt_nxt  = '0;
            end else if (enable && !rempty && r_almost_empty) begin
               w_state_nxt = ST_SINGLE;
            end
         end
         ST_BURST: begin
            w_rinc = w_can_pop;
            if (!enable || rempty) begin
               w_state_nxt = ST_IDLE;
            end else if (w_rinc) begin
               w_bcnt_nxt = r_bcnt + BCNT_W'(1);
               if (r_bcnt == LP_BCNT_LAST) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_SINGLE: begin
            w_rinc = w_can_pop;
            if (!enable || rempty || w_rinc) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_pop_dn = (r_occ != 2'd0) && m_ready;

   // Skid buffer; a simultaneous push and pop implies occupancy was exactly 1
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_occ  <= 2'd0;
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else begin
         case ({w_rinc, w_pop_dn})
            2'b10: begin
               if (r_occ == 2'd0) begin
                  r_buf0 <= rdata;
               end else begin
                  r_buf1 <= rdata;
               end
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_buf0 <= r_buf1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               r_buf0 <= rdata;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_rd_count <= '0;
      end else if (w_rinc) begin
         r_rd_count <= r_rd_count + CNT_W'(1);
      end
   end

`ifdef FIFO_RD_SEQ_CHECK_EN
   logic [DSIZE-1:0] r_seq_exp;
   logic             r_seq_err;

   // Expected value always follows the last popped word, so it resyncs after an error
   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_seq_exp <= '0;
         r_seq_err <= 1'b0;
      end else if (w_rinc) begin
         r_seq_exp <= rdata + DSIZE'(1);
         if (rdata != r_seq_exp) begin
            r_seq_err <= 1'b1;
         end
      end
   end

   assign seq_err = r_seq_err;
`else
   assign seq_err = 1'b0;
`endif

   assign rinc     = w_rinc;
   assign m_valid  = (r_occ != 2'd0);
   assign m_data   = r_buf0;
   assign rd_count = r_rd_count;
   assign busy     = (r_state != ST_IDLE) || (r_occ != 2'd0);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: queue-based FIFO model plus output scoreboard.
module tb_fifo_read_ctrl;

   localparam int unsigned DSIZE     = 8;
   localparam int unsigned BURST_LEN = 4;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned AE_TH     = 2;

   logic             rclk = 1'b0;
   logic             rrst = 1'b1;
   logic [DSIZE-1:0] rdata = '0;
   logic             rempty = 1'b1;
   logic             r_almost_empty = 1'b1;
   logic             rinc;
   logic             enable = 1'b0;
   logic [DSIZE-1:0] m_data;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [CNT_W-1:0] rd_count;
   logic             busy;
   logic             seq_err;

   fifo_read_ctrl #(
      .DSIZE(DSIZE), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
   ) dut (
      .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty),
      .r_almost_empty(r_almost_empty), .rinc(rinc), .enable(enable),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .rd_count(rd_count), .busy(busy), .seq_err(seq_err)
   );

   always #5 rclk = ~rclk;

   // Reference model: FIFO contents, words owed downstream, pop count, sequence flag
   logic [DSIZE-1:0] q_fifo[$];
   logic [DSIZE-1:0] sb[$];
   int unsigned      n_pops = 0;
   logic [DSIZE-1:0] seq_exp = '0;
   logic             seq_flag = 1'b0;
   logic [DSIZE-1:0] next_wr = '0;
   int               errors = 0;
   int               checks = 0;
   int               cyc = 0;
   bit               chk_en = 1'b0;

   logic             drv_rst = 1'b1;
   logic             drv_en = 1'b0;
   logic             drv_rdy = 1'b0;

   logic             obs_rinc, obs_valid, obs_busy, obs_seq;
   logic [DSIZE-1:0] obs_data;
   logic [CNT_W-1:0] obs_count;
   logic             last_rinc = 1'b0;
   logic [DSIZE-1:0] last_word = '0;

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) begin
         q_fifo.push_back(next_wr);
         next_wr = next_wr + 8'd1;
      end
   endtask

   // One clock: drive at negedge, check against model, then advance model at posedge
   task automatic cycle();
      logic ri, acc, legal;
      @(negedge rclk);
      rrst           = drv_rst;
      enable         = drv_en;
      m_ready        = drv_rdy;
      rempty         = (q_fifo.size() == 0);
      r_almost_empty = (q_fifo.size() <= AE_TH);
      rdata          = rempty ? 8'($urandom) : q_fifo[0];
      #1;
      obs_rinc = rinc;  obs_valid = m_valid; obs_busy = busy;
      obs_seq  = seq_err; obs_data = m_data; obs_count = rd_count;
      if (chk_en) begin
         checks++;
         if (m_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, sb.size() != 0);
         end
         if (sb.size() != 0) begin
            checks++;
            if (m_data !== sb[0]) begin
               errors++;
               $display("FAIL m_data cyc=%0d got=%0d exp=%0d", cyc, m_data, sb[0]);
            end
         end
         checks++;
         if (rd_count !== CNT_W'(n_pops)) begin
            errors++;
            $display("FAIL rd_count cyc=%0d got=%0d exp=%0d", cyc, rd_count, n_pops);
         end
         checks++;
         if (seq_err !== seq_flag) begin
            errors++;
            $display("FAIL seq_err cyc=%0d got=%b exp=%b", cyc, seq_err, seq_flag);
         end
         legal = !rempty && enable && (sb.size() < 2);
         checks++;
         if ((rinc !== 1'b0 && rinc !== 1'b1) || (rinc === 1'b1 && !legal)) begin
            errors++;
            $display("FAIL rinc_legal cyc=%0d got=%b allowed=%b", cyc, rinc, legal);
         end
      end
      ri  = rinc;
      acc = m_valid & m_ready;
      @(posedge rclk);
      last_rinc = (ri === 1'b1);
      if (last_rinc && q_fifo.size() != 0) last_word = q_fifo.pop_front();
      if (rrst) begin
         sb.delete();
         n_pops   = 0;
         seq_exp  = '0;
         seq_flag = 1'b0;
         chk_en   = 1'b1;
      end else begin
         if (acc === 1'b1 && sb.size() != 0) void'(sb.pop_front());
         if (last_rinc) begin
            sb.push_back(last_word);
            n_pops++;
`ifdef FIFO_RD_SEQ_CHECK_EN
            if (last_word != seq_exp) seq_flag = 1'b1;
            seq_exp = last_word + 8'd1;
`endif
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      fill(10);
      drv_rst = 1'b1; drv_en = 1'b0; drv_rdy = 1'b1;
      cycle();
      drv_en = 1'b1;
      cycle();
      cycle();
      checks++;
      if (obs_rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got=%b exp=0", obs_rinc); end
      checks++;
      if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", obs_valid); end
      checks++;
      if (obs_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", obs_count); end
      checks++;
      if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", obs_busy); end
      checks++;
      if (obs_data !== '0) begin errors++; $display("FAIL reset_data got=%0d exp=0", obs_data); end
   endtask

   task automatic test_burst();
      logic [5:0]       pat;
      logic [DSIZE-1:0] dat[6];
      logic             vld[6];
      pat = '0;
      drv_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         pat[5-i] = obs_rinc;
         dat[i]   = obs_data;
         vld[i]   = obs_valid;
      end
      checks++;
      if (pat !== 6'b011110) begin
         errors++;
         $display("FAIL burst_rinc_pattern got=%b exp=011110", pat);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (vld[k+2] !== 1'b1 || dat[k+2] !== 8'(k)) begin
            errors++;
            $display("FAIL burst_data idx=%0d got=%0d/v%b exp=%0d/v1", k, dat[k+2], vld[k+2], k);
         end
      end
   endtask

   task automatic test_almost_empty();
      int pops_at[$];
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (obs_rinc === 1'b1) pops_at.push_back(cyc);
      end
      checks++;
      if (pops_at.size() != 6) begin
         errors++;
         $display("FAIL ae_pop_count got=%0d exp=6", pops_at.size());
      end else begin
         checks++;
         if (pops_at[5] - pops_at[4] != 2) begin
            errors++;
            $display("FAIL ae_single_spacing got=%0d exp=2", pops_at[5] - pops_at[4]);
         end
      end
      checks++;
      if (obs_count !== 16'd10) begin errors++; $display("FAIL ae_final_count got=%0d exp=10", obs_count); end
      checks++;
      if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL ae_idle got busy=%b valid=%b exp=0/0", obs_busy, obs_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [DSIZE-1:0] held;
      int               late_pops;
      fill(20);
      drv_rdy = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      drv_rdy   = 1'b0;
      late_pops = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (i == 1) held = obs_data;
         if (i >= 2) begin
            if (obs_rinc === 1'b1) late_pops++;
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== held) begin
               errors++;
               $display("FAIL bp_hold i=%0d got=%0d/v%b exp=%0d/v1", i, obs_data, obs_valid, held);
            end
         end
      end
      checks++;
      if (late_pops != 0) begin errors++; $display("FAIL bp_stall_pops got=%0d exp=0", late_pops); end
      drv_rdy = 1'b1;
      for (int i = 0; i < 40; i++) cycle();
      checks++;
      if (obs_count !== 16'd30 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain got count=%0d valid=%b exp=30/0", obs_count, obs_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drv_en  = ($urandom_range(0, 9) != 0);
         drv_rdy = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 1) == 1 && q_fifo.size() < 16) fill(1);
         cycle();
      end
      drv_en = 1'b1; drv_rdy = 1'b1;
      for (int i = 0; i < 60; i++) cycle();
      checks++;
      if (q_fifo.size() != 0 || obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain got left=%0d valid=%b exp=0/0", q_fifo.size(), obs_valid);
      end
   endtask

   task automatic test_reset_mid();
      fill(6);
      drv_en = 1'b1; drv_rdy = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      checks++;
      if (obs_valid !== 1'b1 || sb.size() != 2) begin
         errors++;
         $display("FAIL rm_prefill got valid=%b occ=%0d exp=1/2", obs_valid, sb.size());
      end
      drv_rst = 1'b1;
      cycle();
      drv_rst = 1'b0;
      cycle();
      checks++;
      if (obs_valid !== 1'b0 || obs_count !== '0 || obs_rinc !== 1'b0) begin
         errors++;
         $display("FAIL rm_after got valid=%b count=%0d rinc=%b exp=0/0/0", obs_valid, obs_count, obs_rinc);
      end
      drv_rdy = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
   endtask

`ifdef FIFO_RD_SEQ_CHECK_EN
   task automatic test_seq_err();
      bit seen3;
      drv_rst = 1'b1;
      cycle();
      q_fifo.delete();
      q_fifo.push_back(8'd0); q_fifo.push_back(8'd1); q_fifo.push_back(8'd3);
      q_fifo.push_back(8'd4); q_fifo.push_back(8'd5);
      drv_rst = 1'b0; drv_en = 1'b1; drv_rdy = 1'b1;
      seen3 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cycle();
         if (seen3) begin
            checks++;
            if (obs_seq !== 1'b1) begin errors++; $display("FAIL seq_err_rise got=%b exp=1", obs_seq); end
         end
         seen3 = last_rinc && (last_word == 8'd3);
      end
      checks++;
      if (obs_seq !== 1'b1) begin errors++; $display("FAIL seq_err_sticky got=%b exp=1", obs_seq); end
   endtask
`endif

   initial begin
      test_reset();
      test_burst();
      test_almost_empty();
      test_backpressure();
      test_random();
      test_reset_mid();
`ifdef FIFO_RD_SEQ_CHECK_EN
      test_seq_err();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
